// File: rtl/gpu_mailbox_pkg.sv
// gpu_mailbox_pkg: register offsets and STATUS/CTRL field positions for the GPU command mailbox
package gpu_mailbox_pkg;
  typedef enum logic [1:0] {OFF_CMD, OFF_STATUS, OFF_CTRL, OFF_RSP} mb_off_e;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_RSP_PEND  = 3;
  localparam int ST_RSP_OVR   = 4;
  localparam int ST_COUNT_LSB = 8;
  localparam int ST_COUNT_MSB = 15;
  localparam int ST_RET_LSB   = 16;
  localparam int ST_RET_MSB   = 31;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR     = 1;
endpackage

// File: rtl/gpu_cmd_mailbox_if.sv
// gpu_cmd_mailbox_if: core data bus, command stream and response strobe of the mailbox
interface gpu_cmd_mailbox_if;
  logic [31:0] bus_addr_i;
  logic [31:0] bus_wr_data_i;
  logic        bus_wr_en_i;
  logic [31:0] bus_rd_data_o;
  logic        bus_hit_o;
  logic        cmd_valid_o;
  logic [31:0] cmd_data_o;
  logic        cmd_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  modport master (
    output bus_addr_i, bus_wr_data_i, bus_wr_en_i, cmd_ready_i, rsp_valid_i, rsp_data_i,
    input  bus_rd_data_o, bus_hit_o, cmd_valid_o, cmd_data_o
  );
  modport slave (
    input  bus_addr_i, bus_wr_data_i, bus_wr_en_i, cmd_ready_i, rsp_valid_i, rsp_data_i,
    output bus_rd_data_o, bus_hit_o, cmd_valid_o, cmd_data_o
  );
endinterface

// File: rtl/gpu_cmd_mailbox_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; a full FIFO still accepts a push when popped that cycle
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic wr, rd;
  assign full_o   = count_q == (AW+1)'(DEPTH);
  assign empty_o  = count_q == '0;
  assign rd       = pop_i & ~flush_i & ~empty_o;
  assign wr       = push_i & ~flush_i & (~full_o | rd);
  assign wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(wr);
  assign rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(rd);
  assign count_d  = flush_i ? '0 : count_q + (AW+1)'(wr) - (AW+1)'(rd);
  assign count_o  = count_q;
  assign data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  always_ff @(posedge clk_i) begin
    wr_ptr_q <= reset_ni ? wr_ptr_d : '0;
    rd_ptr_q <= reset_ni ? rd_ptr_d : '0;
    count_q  <= reset_ni ? count_d : '0;
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/gpu_cmd_mailbox.sv
// gpu_cmd_mailbox: bus-mapped command FIFO to the GPU plus a polled response latch
module gpu_cmd_mailbox
  import gpu_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 16
) (
  input logic               clk_i,
  input logic               reset_ni,
  gpu_cmd_mailbox_if.slave  mb
);
  localparam int AW = $clog2(DEPTH);
  mb_off_e off;
  logic hit, wr_hit, push_req, pop, flush, clr, full, empty;
  logic [AW:0] count;
  logic [15:0] retired_q, retired_d;
  logic overflow_q, overflow_d, rsp_pend_q, rsp_pend_d, rsp_ovr_q, rsp_ovr_d;
  logic [31:0] rsp_data_q, rsp_data_d, status;
  logic unused_addr;
  assign unused_addr = ^mb.bus_addr_i[1:0];
  assign hit      = mb.bus_addr_i[31:4] == BASE_ADDR[31:4];
  assign off      = mb_off_e'(mb.bus_addr_i[3:2]);
  assign wr_hit   = mb.bus_wr_en_i & hit;
  assign push_req = wr_hit & (off == OFF_CMD);
  assign flush    = wr_hit & (off == OFF_CTRL) & mb.bus_wr_data_i[CTRL_FLUSH];
  assign clr      = wr_hit & (off == OFF_CTRL) & mb.bus_wr_data_i[CTRL_CLR];
  assign pop      = mb.cmd_valid_o & mb.cmd_ready_i;
  assign mb.cmd_valid_o = ~empty;
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push_req),
    .pop_i    (pop),
    .flush_i  (flush),
    .data_i   (mb.bus_wr_data_i),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count),
    .data_o   (mb.cmd_data_o)
  );
  // A pop coinciding with flush is discarded by the FIFO, so it is not retired either
  assign retired_d  = retired_q + 16'(pop & ~flush);
  assign overflow_d = (overflow_q & ~clr) | (push_req & full & ~pop);
  assign rsp_pend_d = mb.rsp_valid_i | (rsp_pend_q & ~(wr_hit & (off == OFF_RSP)));
  assign rsp_ovr_d  = (rsp_ovr_q & ~clr) | (mb.rsp_valid_i & rsp_pend_q);
  assign rsp_data_d = mb.rsp_valid_i ? mb.rsp_data_i : rsp_data_q;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVERFLOW] = overflow_q;
    status[ST_RSP_PEND] = rsp_pend_q;
    status[ST_RSP_OVR] = rsp_ovr_q;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = 8'(count);
    status[ST_RET_MSB:ST_RET_LSB] = retired_q;
  end
  assign mb.bus_hit_o     = hit;
  assign mb.bus_rd_data_o = !hit ? '0 : off == OFF_STATUS ? status : off == OFF_RSP ? rsp_data_q : '0;
  always_ff @(posedge clk_i) begin
    retired_q  <= reset_ni ? retired_d : '0;
    overflow_q <= reset_ni ? overflow_d : 1'b0;
    rsp_pend_q <= reset_ni ? rsp_pend_d : 1'b0;
    rsp_ovr_q  <= reset_ni ? rsp_ovr_d : 1'b0;
    rsp_data_q <= reset_ni ? rsp_data_d : '0;
  end
endmodule

// File: tb/tb_gpu_cmd_mailbox.sv
// tb_gpu_cmd_mailbox: directed scenarios for the GPU command mailbox
module tb_gpu_cmd_mailbox;
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int checks = 0;
  int passes = 0;
  localparam logic [31:0] A_CMD = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_CTL = 32'h8000_0008;
  localparam logic [31:0] A_RSP = 32'h8000_000C;

  gpu_cmd_mailbox_if mb();
  gpu_cmd_mailbox #(.BASE_ADDR(32'h8000_0000), .DEPTH(16)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .mb       (mb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mb.bus_addr_i = a;
    mb.bus_wr_data_i = d;
    mb.bus_wr_en_i = 1'b1;
    tick();
    mb.bus_wr_en_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mb.bus_addr_i = a;
    #1;
    d = mb.bus_rd_data_o;
  endtask

  task automatic strobe(input logic [31:0] d);
    mb.rsp_valid_i = 1'b1;
    mb.rsp_data_i = d;
    tick();
    mb.rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_ni = 1'b0;
    repeat (2) tick();
    reset_ni = 1'b1;
    rd(A_ST, r);
    checks++; if (r !== 32'h0000_0001) $display("FAIL reset_status got %h want %h", r, 32'h1); else passes++;
    checks++; if (mb.bus_hit_o !== 1'b1) $display("FAIL reset_hit got %b want 1", mb.bus_hit_o); else passes++;
    checks++; if (mb.cmd_valid_o !== 1'b0 || mb.cmd_data_o !== 32'h0) $display("FAIL reset_stream got %b/%h want 0/0", mb.cmd_valid_o, mb.cmd_data_o); else passes++;
    rd(32'h8000_0007, r);
    checks++; if (r !== 32'h0000_0001) $display("FAIL low_bits_ignored got %h want %h", r, 32'h1); else passes++;
    rd(32'h8000_0010, r);
    checks++; if (r !== 32'h0 || mb.bus_hit_o !== 1'b0) $display("FAIL miss_read got %h/%b want 0/0", r, mb.bus_hit_o); else passes++;
  endtask

  task automatic test_push();
    logic [31:0] r;
    mb.cmd_ready_i = 1'b0;
    wr(A_CMD, 32'hA5A5_0001);
    checks++; if (mb.cmd_valid_o !== 1'b1 || mb.cmd_data_o !== 32'hA5A5_0001) $display("FAIL push_head got %b/%h want 1/a5a50001", mb.cmd_valid_o, mb.cmd_data_o); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0000_0100) $display("FAIL push_status got %h want %h", r, 32'h100); else passes++;
    rd(A_CMD, r);
    checks++; if (r !== 32'h0) $display("FAIL cmd_read got %h want 0", r); else passes++;
    wr(A_CTL, 32'h1);
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    mb.cmd_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) wr(A_CMD, 32'h1000 + i);
    rd(A_ST, r);
    checks++; if (r !== 32'h0000_1006) $display("FAIL ovf_status got %h want %h", r, 32'h1006); else passes++;
    mb.cmd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (mb.cmd_valid_o !== 1'b1 || mb.cmd_data_o !== 32'h1000 + i) $display("FAIL drain_%0d got %b/%h want 1/%h", i, mb.cmd_valid_o, mb.cmd_data_o, 32'h1000 + i); else passes++;
      tick();
    end
    mb.cmd_ready_i = 1'b0;
    checks++; if (mb.cmd_valid_o !== 1'b0) $display("FAIL drain_empty got %b want 0", mb.cmd_valid_o); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0010_0005) $display("FAIL drained_status got %h want %h", r, 32'h0010_0005); else passes++;
    wr(A_CTL, 32'h2);
    rd(A_ST, r);
    checks++; if (r !== 32'h0010_0001) $display("FAIL clear_sticky got %h want %h", r, 32'h0010_0001); else passes++;
    wr(32'h8000_0010, 32'hDEAD_BEEF);
    rd(A_ST, r);
    checks++; if (r !== 32'h0010_0001) $display("FAIL miss_write got %h want %h", r, 32'h0010_0001); else passes++;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] r;
    mb.cmd_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) wr(A_CMD, 32'h2000 + i);
    mb.cmd_ready_i = 1'b1;
    wr(A_CMD, 32'h2FFF);
    mb.cmd_ready_i = 1'b0;
    rd(A_ST, r);
    checks++; if (r !== 32'h0011_1002) $display("FAIL full_pushpop_status got %h want %h", r, 32'h0011_1002); else passes++;
    mb.cmd_ready_i = 1'b1;
    for (int i = 1; i < 17; i++) begin
      checks++; if (mb.cmd_data_o !== (i == 16 ? 32'h2FFF : 32'h2000 + i)) $display("FAIL pp_drain_%0d got %h want %h", i, mb.cmd_data_o, (i == 16 ? 32'h2FFF : 32'h2000 + i)); else passes++;
      tick();
    end
    mb.cmd_ready_i = 1'b0;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0001) $display("FAIL pp_final_status got %h want %h", r, 32'h0021_0001); else passes++;
  endtask

  task automatic test_flush();
    logic [31:0] r;
    for (int i = 0; i < 3; i++) wr(A_CMD, 32'h3000 + i);
    mb.cmd_ready_i = 1'b1;
    wr(A_CTL, 32'h1);
    mb.cmd_ready_i = 1'b0;
    checks++; if (mb.cmd_valid_o !== 1'b0 || mb.cmd_data_o !== 32'h0) $display("FAIL flush_stream got %b/%h want 0/0", mb.cmd_valid_o, mb.cmd_data_o); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0001) $display("FAIL flush_status got %h want %h", r, 32'h0021_0001); else passes++;
    for (int i = 0; i < 17; i++) wr(A_CMD, 32'h4000 + i);
    wr(A_CTL, 32'h2);
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_1002) $display("FAIL clr_only_status got %h want %h", r, 32'h0021_1002); else passes++;
    wr(A_CTL, 32'h1);
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0001) $display("FAIL flush_full_status got %h want %h", r, 32'h0021_0001); else passes++;
  endtask

  task automatic test_rsp();
    logic [31:0] r;
    strobe(32'h1234);
    rd(A_RSP, r);
    checks++; if (r !== 32'h1234) $display("FAIL rsp_first got %h want %h", r, 32'h1234); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0009) $display("FAIL rsp_pending got %h want %h", r, 32'h0021_0009); else passes++;
    strobe(32'h5678);
    rd(A_RSP, r);
    checks++; if (r !== 32'h5678) $display("FAIL rsp_second got %h want %h", r, 32'h5678); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0019) $display("FAIL rsp_overrun got %h want %h", r, 32'h0021_0019); else passes++;
    mb.rsp_valid_i = 1'b1;
    mb.rsp_data_i = 32'h9ABC;
    wr(A_RSP, 32'h0);
    mb.rsp_valid_i = 1'b0;
    rd(A_RSP, r);
    checks++; if (r !== 32'h9ABC) $display("FAIL rsp_third got %h want %h", r, 32'h9ABC); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0019) $display("FAIL rsp_ack_collide got %h want %h", r, 32'h0021_0019); else passes++;
    wr(A_RSP, 32'h0);
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0011) $display("FAIL rsp_ack got %h want %h", r, 32'h0021_0011); else passes++;
    strobe(32'h1111);
    mb.rsp_valid_i = 1'b1;
    mb.rsp_data_i = 32'h2222;
    wr(A_CTL, 32'h2);
    mb.rsp_valid_i = 1'b0;
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0019) $display("FAIL ovr_set_wins got %h want %h", r, 32'h0021_0019); else passes++;
    wr(A_CTL, 32'h2);
    rd(A_ST, r);
    checks++; if (r !== 32'h0021_0009) $display("FAIL ovr_clear got %h want %h", r, 32'h0021_0009); else passes++;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] r;
    wr(A_CMD, 32'h5000);
    wr(A_CMD, 32'h5001);
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    checks++; if (mb.cmd_valid_o !== 1'b0 || mb.cmd_data_o !== 32'h0) $display("FAIL midreset_stream got %b/%h want 0/0", mb.cmd_valid_o, mb.cmd_data_o); else passes++;
    rd(A_ST, r);
    checks++; if (r !== 32'h0000_0001) $display("FAIL midreset_status got %h want %h", r, 32'h1); else passes++;
    rd(A_RSP, r);
    checks++; if (r !== 32'h0) $display("FAIL midreset_rsp got %h want 0", r); else passes++;
  endtask

  initial begin
    mb.bus_addr_i = '0;
    mb.bus_wr_data_i = '0;
    mb.bus_wr_en_i = 1'b0;
    mb.cmd_ready_i = 1'b0;
    mb.rsp_valid_i = 1'b0;
    mb.rsp_data_i = '0;
    test_reset();
    test_push();
    test_overflow();
    test_full_pushpop();
    test_flush();
    test_rsp();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gpu_cmd_mailbox.md
Name: gpu_cmd_mailbox

Overview:
- Memory-mapped bus responder for the processor's single-cycle data bus. The core drives the address, write data and write enable; read data is returned combinationally in the same cycle.
- Buffers 32-bit command words, written by the core, in a FIFO and presents them to the GPU front end over a valid/ready stream.
- Latches a single response word from the GPU for the core to poll.
- Sits behind the bus address decoder alongside data RAM.

Parameters:
- BASE_ADDR, 32'h8000_0000: base of the 16-byte register window; must be 16-byte aligned.
- DEPTH, 16: command FIFO depth; must be a power of 2, range 2..128.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  reset; synchronous, active-low.
- bus_addr_i  in  32  byte address from core.
- bus_wr_data_i  in  32  write data.
- bus_wr_en_i  in  1  write strobe, one cycle per store.
- bus_rd_data_o  out  32  combinational read data.
- bus_hit_o  out  1  combinational; address falls inside the window, for the interconnect read mux.
- cmd_valid_o  out  1  FIFO non-empty.
- cmd_data_o  out  32  FIFO head word.
- cmd_ready_i  in  1  GPU accepts the head word.
- rsp_valid_i  in  1  single-cycle response strobe from GPU.
- rsp_data_i  in  32  response word.

Behaviour:
- Decode: hit = (bus_addr_i[31:4] == BASE_ADDR[31:4]). Offset = bus_addr_i[3:2]; bus_addr_i[1:0] is ignored.
- On a miss, bus_rd_data_o = 0 and writes are ignored.
- There are no read side effects, because the bus has no read strobe.
- Register map:
  - 0x0 CMD: a write pushes bus_wr_data_i. Reads return 0.
  - 0x4 STATUS (read-only):
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [3] rsp_pending
    - [4] rsp_overrun (sticky)
    - [15:8] count, zero-extended
    - [31:16] retired, a 16-bit pop counter
  - 0x8 CTRL (write-only, reads return 0):
    - bit0 = 1 flushes the FIFO.
    - bit1 = 1 clears overflow and rsp_overrun.
    - Both bits may be set in one write.
  - 0xC RSP: reads return the latched response. Any write clears rsp_pending.
- Reset (reset_ni = 0 at a clock edge): FIFO pointers, count, retired, sticky bits, rsp_pending and the response register all become 0. Outputs after reset: cmd_valid_o = 0, cmd_data_o = 0. Reset mid-stream discards all buffered words.
- pop = cmd_valid_o & cmd_ready_i. retired increments on each pop and wraps 0xFFFF to 0.
- push_req = bus_wr_en_i & hit & offset 0.
  - The push is accepted if !full, or if full and pop happens in the same cycle.
  - Otherwise the word is dropped and overflow sets.
- Push and pop in the same cycle leave count unchanged.
- Latency: a pushed word is visible on cmd_valid_o/cmd_data_o the next cycle. There is no write-through to the stream in the same cycle.
- cmd_data_o = mem[rd_ptr] when non-empty, else 0.
- Flush (CTRL bit0) has priority over push and pop in the same cycle:
  - count and pointers become 0; retired is unchanged.
  - A push in that cycle is impossible, since it targets a different offset.
  - A pop asserted by the GPU in the flush cycle is not counted.
  - cmd_valid_o is 0 from the next cycle.
- Overflow-clear and a new overflow in the same cycle cannot coincide, because they target different offsets.
- Response handling:
  - rsp_valid_i latches rsp_data_i and sets rsp_pending.
  - If rsp_pending is already 1, the data is overwritten and rsp_overrun sets.
  - If rsp_valid_i and an RSP write occur in the same cycle, the new data is latched and rsp_pending stays 1.
  - If rsp_valid_i and a CTRL bit1 write occur in the same cycle with rsp_pending already set, rsp_overrun ends at 1 (set wins).
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits; full = (count == DEPTH).

Decomposition:
- Package gpu_mailbox_pkg holds:
  - offset constants OFF_CMD, OFF_STATUS, OFF_CTRL, OFF_RSP;
  - STATUS bit positions and field ranges;
  - CTRL bit positions.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, flush, full, empty, count and head data. The mailbox wraps it with decode, sticky bits, the response latch and the retired counter.

Test Plan:
- Reset, then read 0x8000_0004 -> 0x0000_0001 (empty); cmd_valid_o = 0; read of 0x8000_0010 (miss) -> 0, bus_hit_o = 0.
- Write 0xA5A5_0001 to 0x8000_0000 with cmd_ready_i = 0 -> next cycle cmd_valid_o = 1, cmd_data_o = 0xA5A5_0001; STATUS count = 1.
- With cmd_ready_i = 0, push 17 words (DEPTH = 16) -> STATUS full = 1, overflow = 1, count = 16; word 17 is absent. Then raise ready, which drains 16 words in order -> retired = 16, empty = 1.
- With the FIFO full, push while cmd_ready_i = 1 in the same cycle -> word accepted, count stays 16, overflow stays 0.
- Three pushes, then write 0x1 to 0x8000_0008 -> next cycle cmd_valid_o = 0, count = 0, retired unchanged. Write 0x2 -> sticky bits cleared.
- Response handling:
  - rsp_valid_i with 0x1234 -> RSP reads 0x1234, STATUS[3] = 1.
  - A second strobe with 0x5678 -> RSP reads 0x5678, STATUS[4] = 1.
  - A write to 0xC in the same cycle as a third strobe -> rsp_pending stays 1.
